// File: rtl/dmem_master.sv
// rtl/dmem_master.sv - load/store initiator for the single-port data memory's shared tri-state bus
module dmem_master #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req_bad;

  // Misaligned or beyond the last memory word: answered without touching the bus.
  assign req_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);

  // Bus ownership follows the mem_we flop, so both sides hand over on the same edge.
  assign mem_data   = mem_we_q ? wdata_q : {DATA_W{1'bz}};
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Next-state and registered-output computation for the bus sequencer.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ready_d = 1'b0;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_addr_d = req_addr[ADDR_W+1:2];
            wdata_d    = req_wdata;
            if (req_we) begin
              state_d  = WRITE;
              mem_we_d = 1'b1;
            end else begin
              state_d = READ;
              cnt_d   = WAIT_INIT;
            end
          end
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// tb/tb_dmem_master.sv - two dmem_master instances (READ_WAIT 0 and 3) against a behavioural model
module tb_dmem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req_valid, req_we;
  logic [31:0]       req_addr, req_wdata;
  logic [1:0]        d_ready, d_rv, d_err, d_we;
  logic [1:0][31:0]  d_rdata;
  logic [1:0][5:0]   d_addr;
  wire  [31:0]       bus0, bus1;
  logic [31:0]       mem0 [64];
  logic [31:0]       mem1 [64];

  dmem_master #(.ADDR_W(6), .DATA_W(32), .READ_WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(d_rv[0]), .resp_rdata(d_rdata[0]), .resp_err(d_err[0]),
    .mem_we(d_we[0]), .mem_addr(d_addr[0]), .mem_data(bus0));

  dmem_master #(.ADDR_W(6), .DATA_W(32), .READ_WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(d_rv[1]), .resp_rdata(d_rdata[1]), .resp_err(d_err[1]),
    .mem_we(d_we[1]), .mem_addr(d_addr[1]), .mem_data(bus1));

  // Memories: drive the bus while write enable is low, capture on posedge when high.
  assign bus0 = d_we[0] ? 32'bz : mem0[d_addr[0]];
  assign bus1 = d_we[1] ? 32'bz : mem1[d_addr[1]];

  always @(posedge clk) begin
    if (d_we[0]) mem0[d_addr[0]] <= bus0;
    if (d_we[1]) mem1[d_addr[1]] <= bus1;
  end

  int checks = 0;
  int failures = 0;

  // Reference model state: one outstanding request per instance, timed by latency.
  int          cyc = 0;
  bit          pend [2];
  int          acc [2];
  int          lat [2];
  bit          p_st [2];
  bit          p_err [2];
  bit          p_known [2];
  logic [31:0] p_wdata [2];
  logic [31:0] p_rdata [2];
  logic [5:0]  p_word [2];
  bit          e_ready [2];
  bit          e_we [2];
  bit          e_rv [2];
  bit          e_err [2];
  bit          e_known [2];
  logic [31:0] e_rdata [2];
  logic [5:0]  e_addr [2];
  logic [31:0] ref_mem [2][64];
  bit          ref_ok [2][64];

  function automatic int read_wait(int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] bus_of(int i);
    return (i == 0) ? bus0 : bus1;
  endfunction

  function automatic logic [31:0] mem_of(int i, logic [5:0] w);
    return (i == 0) ? mem0[w] : mem1[w];
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h cyc=%0d", name, i, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && p_st[i] && cyc == acc[i]) ref_ok[i][p_word[i]] = 1'b0;
      pend[i] = 0; e_ready[i] = 1; e_we[i] = 0; e_rv[i] = 0; e_err[i] = 0;
      e_known[i] = 1; e_rdata[i] = '0; e_addr[i] = '0;
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int k;
      bit bad;
      if (e_ready[i] && req_valid) begin
        bad = (req_addr[1:0] != 2'b00) || (req_addr >= 32'h100);
        pend[i] = 1; acc[i] = cyc; p_err[i] = bad; p_st[i] = req_we && !bad;
        p_rdata[i] = '0; p_known[i] = 1;
        if (bad) begin
          lat[i] = 1;
        end else begin
          p_word[i] = req_addr[7:2];
          e_addr[i] = req_addr[7:2];
          if (req_we) begin
            lat[i] = 2;
            p_wdata[i] = req_wdata;
            ref_mem[i][p_word[i]] = req_wdata;
            ref_ok[i][p_word[i]] = 1;
          end else begin
            lat[i] = read_wait(i) + 2;
            p_rdata[i] = ref_mem[i][p_word[i]];
            p_known[i] = ref_ok[i][p_word[i]];
          end
        end
      end
      if (pend[i]) begin
        k = cyc - acc[i];
        e_we[i] = p_st[i] && (k == 0);
        e_rv[i] = (k == lat[i] - 1);
        if (e_rv[i]) begin
          e_rdata[i] = p_rdata[i]; e_err[i] = p_err[i]; e_known[i] = p_known[i];
        end
        e_ready[i] = (k >= lat[i]);
        if (k >= lat[i]) pend[i] = 0;
      end else begin
        e_ready[i] = 1; e_we[i] = 0; e_rv[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("req_ready", i, 32'(d_ready[i]), 32'(e_ready[i]));
      chk("resp_valid", i, 32'(d_rv[i]), 32'(e_rv[i]));
      chk("mem_we", i, 32'(d_we[i]), 32'(e_we[i]));
      chk("mem_addr", i, 32'(d_addr[i]), 32'(e_addr[i]));
      chk("resp_err", i, 32'(d_err[i]), 32'(e_err[i]));
      if (e_known[i]) chk("resp_rdata", i, d_rdata[i], e_rdata[i]);
      if (e_we[i]) chk("bus_wdata", i, bus_of(i), p_wdata[i]);
      else         chk("bus_mem", i, bus_of(i), mem_of(i, e_addr[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(bit we, logic [31:0] addr, logic [31:0] data);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(e_ready[0] && e_ready[1]) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!(e_ready[0] && e_ready[1])) begin
      failures++;
      $display("FAIL wait_idle timeout got=%0d expected=<40", n);
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mem_we", i, 32'(d_we[i]), 32'd0);
      chk("rst_resp_valid", i, 32'(d_rv[i]), 32'd0);
      chk("rst_bus_released", i, bus_of(i), mem_of(i, d_addr[i]));
    end
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n_rv0, n_rv1;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("lit_reset_ready", i, 32'(d_ready[i]), 32'd1);
      chk("lit_reset_addr", i, 32'(d_addr[i]), 32'd0);
      chk("lit_reset_rdata", i, d_rdata[i], 32'd0);
    end

    for (int w = 0; w < 64; w++) begin
      issue(1'b1, 32'(w) << 2, $urandom);
      wait_idle();
    end
    async_reset();
    tick();

    issue(1'b1, 32'h0000_0014, 32'hDEADBEEF);
    chk("lit_st_we", 0, 32'(d_we[0]), 32'd1);
    chk("lit_st_addr", 0, 32'(d_addr[0]), 32'd5);
    chk("lit_st_bus", 0, bus0, 32'hDEADBEEF);
    tick();
    chk("lit_st_rv", 0, 32'(d_rv[0]), 32'd1);
    chk("lit_st_rv", 1, 32'(d_rv[1]), 32'd1);
    chk("lit_st_rdata", 0, d_rdata[0], 32'd0);
    wait_idle();

    issue(1'b0, 32'h0000_0014, 32'h0);
    chk("lit_ld_we", 0, 32'(d_we[0]), 32'd0);
    tick();
    chk("lit_ld_rv", 0, 32'(d_rv[0]), 32'd1);
    chk("lit_ld_rdata", 0, d_rdata[0], 32'hDEADBEEF);
    chk("lit_ld_rv_wait3", 1, 32'(d_rv[1]), 32'd0);
    repeat (3) tick();
    chk("lit_ld_rv", 1, 32'(d_rv[1]), 32'd1);
    chk("lit_ld_rdata", 1, d_rdata[1], 32'hDEADBEEF);
    wait_idle();

    issue(1'b0, 32'h0000_0016, 32'h0);
    chk("lit_mis_err", 0, 32'(d_err[0]), 32'd1);
    chk("lit_mis_rv", 1, 32'(d_rv[1]), 32'd1);
    chk("lit_mis_addr", 1, 32'(d_addr[1]), 32'd5);
    wait_idle();
    issue(1'b1, 32'h0000_0100, 32'hA5A5A5A5);
    chk("lit_oor_err", 1, 32'(d_err[1]), 32'd1);
    chk("lit_oor_we", 0, 32'(d_we[0]), 32'd0);
    chk("lit_oor_addr", 0, 32'(d_addr[0]), 32'd5);
    wait_idle();

    n_rv0 = 0; n_rv1 = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_00FC;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) chk("lit_top_addr", 1, 32'(d_addr[1]), 32'd63);
      n_rv0 += int'(d_rv[0]);
      n_rv1 += int'(d_rv[1]);
    end
    req_valid = 1'b0;
    chk("lit_hold_resps", 0, 32'(n_rv0), 32'd4);
    chk("lit_hold_resps", 1, 32'(n_rv1), 32'd2);
    wait_idle();

    issue(1'b1, 32'h0000_0080, 32'h12345678);
    chk("lit_abort_we", 0, 32'(d_we[0]), 32'd1);
    async_reset();
    repeat (6) tick();
    issue(1'b0, 32'h0000_00FC, 32'h0);
    tick();
    async_reset();
    repeat (6) tick();
    issue(1'b0, 32'h0000_0014, 32'h0);
    wait_idle();

    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      case ($urandom_range(0, 9))
        0: req_addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        1: req_addr = $urandom | 32'h0000_0100;
        2: req_addr = 32'h0000_00FC;
        3: req_addr = 32'h0000_0100;
        default: req_addr = 32'($urandom_range(0, 15)) << 2;
      endcase
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end
    req_valid = 1'b0;
    wait_idle();

    for (int w = 0; w < 64; w++) begin
      if (ref_ok[0][w]) chk("mem_word", 0, mem0[w], ref_mem[0][w]);
      if (ref_ok[1][w]) chk("mem_word", 1, mem1[w], ref_mem[1][w]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
